pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the consecutive-stall cycle count at which stall_timeout is raised.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port stallreq_if / stallreq_id / stallreq_ex / stallreq_mem, input, 1 each, stall requests from the IF, ID, EX and MEM stages.
REQ-005 SHALL have port branch_flag, input, 1, and branch_target, input, 32, a taken-branch redirect from EX.
REQ-006 SHALL have port trap_req, input, 1, and trap_vec, input, 32, a precise trap raised at MEM, with its handler address.
REQ-007 SHALL have port stall, output, 5, the hold controls [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB.
REQ-008 SHALL have port flush_ifid / flush_idex / flush_exmem, output, 1 each, which zero the named pipeline register on the next edge.
REQ-009 SHALL have port new_pc_valid, output, 1, and new_pc, output, 32, the fetch redirect.
REQ-010 SHALL have port stall_timeout, output, 1, a sticky watchdog flag.
REQ-011 SHALL have port stall_cycles, output, 32, a performance count of PC-hold cycles.

Function
REQ-012 SHALL implement a two-state FSM: RUN and TRAP.
REQ-013 stall, the flush outputs, new_pc_valid and new_pc SHALL be combinational from the inputs and the state, taking effect in the same cycle.
REQ-014 In RUN, SHALL apply this priority, highest first: trap_req > stallreq_mem > stallreq_ex > branch_flag > stallreq_id > stallreq_if.
REQ-015 On trap_req in RUN: all three flushes SHALL be 1, stall SHALL be 0, trap_vec SHALL be captured, and the FSM SHALL move to TRAP.
REQ-016 In TRAP, for exactly one cycle: new_pc_valid SHALL be 1 with new_pc equal to the captured vector, the flushes and stall SHALL be 0, and the FSM SHALL return to RUN.
REQ-017 trap_req SHALL be ignored while in TRAP; all stall requests in TRAP SHALL be ignored.
REQ-018 stallreq_mem SHALL drive stall=01111; stallreq_ex SHALL drive stall=00111; stallreq_id SHALL drive stall=00011; stallreq_if SHALL drive stall=00001.
REQ-019 The pipeline registers insert a bubble where stall[i]=1 and stall[i+1]=0; this block SHALL NOT assert a flush for stall bubbles.
REQ-020 branch_flag SHALL be honoured only in RUN with trap_req=0, stallreq_mem=0 and stallreq_ex=0; an honoured branch SHALL give new_pc_valid=1, new_pc=branch_target, flush_ifid=1, flush_idex=1 and stall=00000, overriding stallreq_id and stallreq_if.
REQ-021 A suppressed branch_flag SHALL produce no effect; EX re-presents it after the stall clears.
REQ-022 When no event is active, new_pc SHALL be 0 and every output SHALL be 0.
REQ-023 A consecutive-stall counter (8 bits minimum, saturating) SHALL increment each cycle with stall!=0 and clear on any cycle with stall==0.
REQ-024 When the consecutive-stall counter equals TIMEOUT, stall_timeout SHALL be set and SHALL stay set until reset.
REQ-025 stall_cycles SHALL increment on every cycle with stall[0]=1, wrapping modulo 2^32.
REQ-026 A trap SHALL NOT clear stall_timeout or stall_cycles.

Reset
REQ-027 While rst=0, the FSM SHALL be RUN, the captured vector 0, both counters 0 and stall_timeout 0.
REQ-028 While rst=0, all combinational outputs SHALL be forced to 0 regardless of the inputs.
REQ-029 An assertion of rst in TRAP SHALL abort the redirect; after release the FSM SHALL be in RUN with new_pc_valid=0.

Verification
REQ-030 Scenario: stallreq_ex=1 for 3 cycles -> stall=00111 for those 3 cycles and stall_cycles=3.
REQ-031 Scenario: branch_flag=1, branch_target=0x0000_0100, stallreq_id=1 -> stall=00000, flush_ifid=1, flush_idex=1, new_pc=0x100, new_pc_valid=1 in the same cycle.
REQ-032 Scenario: branch_flag=1 with stallreq_mem=1 -> stall=01111, new_pc_valid=0, no flush.
REQ-033 Scenario: trap_req=1, trap_vec=0x8000_0004, followed by a second trap_req on the next cycle -> cycle 0: all three flushes=1; cycle 1: new_pc_valid=1, new_pc=0x8000_0004, second trap_req ignored; cycle 2: FSM in RUN.
REQ-034 Scenario: stallreq_if held for 255 cycles with TIMEOUT=255 -> stall_timeout=1 and it remains 1 after stallreq_if drops.
REQ-035 Scenario: rst=0 asserted asynchronously in the TRAP cycle -> new_pc_valid drops immediately, and all outputs are 0 after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates stage stall requests, taken-branch
// redirects and precise MEM traps into per-stage hold/flush controls and a
// fetch redirect. It also keeps a sticky stall watchdog and a PC-hold
// performance counter.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  output logic [4:0]  stall,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        new_pc_valid,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  // The watchdog counter is at least 8 bits wide.
  // It is widened when TIMEOUT needs more bits.
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [31:0]     cyc_q, cyc_d;

  logic [4:0]      stall_c;
  logic            fl_ifid_c, fl_idex_c, fl_exmem_c;
  logic            npv_c;
  logic [31:0]     npc_c;

  // Priority decode of hazards into hold/flush/redirect for the current cycle.
  always_comb begin
    stall_c    = '0;
    fl_ifid_c  = 1'b0;
    fl_idex_c  = 1'b0;
    fl_exmem_c = 1'b0;
    npv_c      = 1'b0;
    npc_c      = '0;
    state_d    = state_q;
    vec_d      = vec_q;
    if (state_q == TRAP) begin
      // Redirect to the handler for one cycle. Every request is ignored here.
      npv_c   = 1'b1;
      npc_c   = vec_q;
      state_d = RUN;
    end else if (trap_req) begin
      fl_ifid_c  = 1'b1;
      fl_idex_c  = 1'b1;
      fl_exmem_c = 1'b1;
      vec_d      = trap_vec;
      state_d    = TRAP;
    end else if (stallreq_mem) begin
      stall_c = 5'b01111;
    end else if (stallreq_ex) begin
      stall_c = 5'b00111;
    end else if (branch_flag) begin
      // A branch beats the younger stalls. The stalled work is flushed anyway.
      npv_c     = 1'b1;
      npc_c     = branch_target;
      fl_ifid_c = 1'b1;
      fl_idex_c = 1'b1;
    end else if (stallreq_id) begin
      stall_c = 5'b00011;
    end else if (stallreq_if) begin
      stall_c = 5'b00001;
    end
    // While reset is held, force the controls quiet whatever the inputs are.
    if (!rst) begin
      stall_c    = '0;
      fl_ifid_c  = 1'b0;
      fl_idex_c  = 1'b0;
      fl_exmem_c = 1'b0;
      npv_c      = 1'b0;
      npc_c      = '0;
    end
  end

  assign stall        = stall_c;
  assign flush_ifid   = fl_ifid_c;
  assign flush_idex   = fl_idex_c;
  assign flush_exmem  = fl_exmem_c;
  assign new_pc_valid = npv_c;
  assign new_pc       = npc_c;

  // Next-state for the watchdog and the performance counter.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    cyc_d     = cyc_q;
    if (stall_c != '0) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
    if (cnt_q == CW'(TIMEOUT)) timeout_d = 1'b1;
    if (stall_c[0]) cyc_d = cyc_q + 32'd1;
  end

  // FSM state and captured trap vector. Reset aborts any pending redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // Counters and sticky watchdog flag. A trap does not clear them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      cyc_q     <= cyc_d;
    end
  end

  assign stall_timeout = timeout_q;
  assign stall_cycles  = cyc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Each step pushes its expected controls into a
// scoreboard queue. The queue is popped and compared mid-cycle.
module tb_pipe_ctrl;
  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        sif, sid, sex, smem, br, trap;
  logic [31:0] bt, tv;
  logic [4:0]  stall;
  logic        fi, fd, fe, npv;
  logic [31:0] npc;
  logic        sto;
  logic [31:0] scyc;

  typedef struct packed {
    logic [4:0]  stall;
    logic [2:0]  fl;
    logic        npv;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .branch_flag(br), .branch_target(bt), .trap_req(trap), .trap_vec(tv),
    .stall(stall), .flush_ifid(fi), .flush_idex(fd), .flush_exmem(fe),
    .new_pc_valid(npv), .new_pc(npc), .stall_timeout(sto), .stall_cycles(scyc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare the live combinational outputs.
  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".stall"}, {27'd0, stall}, {27'd0, e.stall});
    chk({tag, ".flush"}, {29'd0, fi, fd, fe}, {29'd0, e.fl});
    chk({tag, ".npv"}, {31'd0, npv}, {31'd0, e.npv});
    chk({tag, ".npc"}, npc, e.npc);
  endtask

  // Drive one cycle of requests on the falling edge, then check before the rising edge.
  task automatic cycle(input logic t, m, e, b, d, f,
                       input logic [31:0] vbt, vtv,
                       input logic [4:0] es, input logic [2:0] efl,
                       input logic enpv, input logic [31:0] enpc, input string tag);
    exp_t x;
    @(negedge clk);
    trap = t; smem = m; sex = e; br = b; sid = d; sif = f; bt = vbt; tv = vtv;
    x.stall = es; x.fl = efl; x.npv = enpv; x.npc = enpc;
    sb.push_back(x);
    #2;
    check_out(tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'b0, 3'b0, 1'b0, 32'h0, tag);
  endtask

  initial begin
    rst = 1'b0;
    {trap, smem, sex, br, sid, sif} = 6'b111111;
    bt = 32'hFFFF_FFFF; tv = 32'hFFFF_FFFF;

    // Reset holds every output low, even with all requests active.
    cycle(1, 1, 1, 1, 1, 1, 32'h100, 32'h44, 5'b0, 3'b0, 1'b0, 32'h0, "rst_force");
    chk("rst.scyc", scyc, 32'd0);
    chk("rst.sto", {31'd0, sto}, 32'd0);
    @(negedge clk);
    {trap, smem, sex, br, sid, sif} = 6'b0;
    rst = 1'b1;

    idle("idle0");

    // Three cycles of an EX stall.
    repeat (3) cycle(0, 0, 1, 0, 0, 0, 0, 0, 5'b00111, 3'b0, 1'b0, 32'h0, "ex_stall");
    idle("idle1");
    chk("ex.scyc", scyc, 32'd3);

    // A branch overrides an ID stall.
    cycle(0, 0, 0, 1, 1, 0, 32'h100, 0, 5'b00000, 3'b110, 1'b1, 32'h100, "br_id");
    // A branch is suppressed by MEM and EX stalls.
    cycle(0, 1, 0, 1, 0, 0, 32'h100, 0, 5'b01111, 3'b000, 1'b0, 32'h0, "br_mem");
    cycle(0, 0, 1, 1, 0, 0, 32'h200, 0, 5'b00111, 3'b000, 1'b0, 32'h0, "br_ex");
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 5'b00011, 3'b0, 1'b0, 32'h0, "id_stall");
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 3'b0, 1'b0, 32'h0, "if_stall");
    cycle(0, 1, 1, 0, 1, 1, 0, 0, 5'b01111, 3'b0, 1'b0, 32'h0, "all_stall");
    idle("idle2");
    chk("mix.scyc", scyc, 32'd8);

    // A trap is followed by a back-to-back trap request, which is ignored.
    cycle(1, 1, 1, 1, 1, 1, 32'h100, 32'h8000_0004, 5'b0, 3'b111, 1'b0, 32'h0, "trap0");
    cycle(1, 1, 1, 1, 1, 1, 32'h100, 32'hDEAD_BEEF, 5'b0, 3'b000, 1'b1, 32'h8000_0004, "trap1");
    idle("trap2_run");
    cycle(0, 0, 0, 1, 0, 0, 32'h300, 0, 5'b0, 3'b110, 1'b1, 32'h300, "br_after_trap");
    chk("trap.scyc", scyc, 32'd8);

    // Watchdog fires after TIMEOUT consecutive stall cycles and stays sticky.
    repeat (TIMEOUT) cycle(0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 3'b0, 1'b0, 32'h0, "wd_if");
    chk("wd.pre", {31'd0, sto}, 32'd0);
    idle("wd_idle0");
    idle("wd_idle1");
    chk("wd.set", {31'd0, sto}, 32'd1);
    idle("wd_idle2");
    idle("wd_idle3");
    chk("wd.sticky", {31'd0, sto}, 32'd1);
    chk("wd.scyc", scyc, 32'd8 + TIMEOUT);

    // An asynchronous reset in the TRAP cycle kills the redirect at once.
    cycle(1, 0, 0, 0, 0, 0, 0, 32'h1234, 5'b0, 3'b111, 1'b0, 32'h0, "rtrap0");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 3'b000, 1'b1, 32'h1234, "rtrap1");
    #1 rst = 1'b0;
    #1;
    chk("rtrap.npv", {31'd0, npv}, 32'd0);
    chk("rtrap.npc", npc, 32'd0);
    chk("rtrap.sto", {31'd0, sto}, 32'd0);
    chk("rtrap.scyc", scyc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle("rtrap_release");
    idle("rtrap_run");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
